// File: rtl/filter_arbiter_pkg.sv
// Shared constants and helpers for the filter-buffer read scheduler.
// DATA_WIDTH is the particle-pair width also used by the filter buffers.
package filter_arbiter_pkg;

   localparam int NUM_FILTER      = 8;
   localparam int DATA_WIDTH      = 32;
   localparam int FILTER_ID_WIDTH = 3;

   typedef logic [FILTER_ID_WIDTH-1:0] filter_id_t;

   // Modulo-NUM_FILTER successor of a buffer index.
   function automatic filter_id_t next_id(input filter_id_t g);
      filter_id_t r;
      if (g == FILTER_ID_WIDTH'(NUM_FILTER - 1)) begin
         r = {FILTER_ID_WIDTH{1'b0}};
      end else begin
         r = g + FILTER_ID_WIDTH'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/filter_arbiter_if.sv
// Bundle of filter-buffer flags/data, force-pipeline handshake and status.
// master = arbiter side, slave = buffers plus force pipeline.
interface filter_arbiter_if;
   import filter_arbiter_pkg::*;

   logic [NUM_FILTER-1:0]            filter_empty;
   logic [NUM_FILTER-1:0]            filter_full;
   logic [NUM_FILTER*DATA_WIDTH-1:0] filter_q;
   logic [NUM_FILTER-1:0]            filter_rdreq;
   logic                             stall;
   logic [DATA_WIDTH-1:0]            out_data;
   logic [FILTER_ID_WIDTH-1:0]       out_filter_id;
   logic                             out_valid;
   logic                             idle;

   modport master (
      input  filter_empty, filter_full, filter_q, stall,
      output filter_rdreq, out_data, out_filter_id, out_valid, idle
   );

   modport slave (
      output filter_empty, filter_full, filter_q, stall,
      input  filter_rdreq, out_data, out_filter_id, out_valid, idle
   );

endinterface

// File: rtl/filter_arbiter_rr_priority_encoder.sv
// Rotating priority encoder: first set request searching start, start+1, ...
// with modulo-N wrap; returns one-hot grant, its index and an any flag.
module rr_priority_encoder #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any_grant
);

   // Search loop; the found flag keeps the first hit in rotation order.
   always_comb begin
      any_grant = 1'b0;
      idx       = {IDX_W{1'b0}};
      grant     = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         int cand;
         cand = (int'(start) + i) % N;
         if (!any_grant && req[cand]) begin
            any_grant = 1'b1;
            idx       = IDX_W'(cand);
         end else begin
            any_grant = any_grant;
         end
      end
      if (any_grant) begin
         grant = {{(N-1){1'b0}}, 1'b1} << idx;
      end else begin
         grant = {N{1'b0}};
      end
   end

endmodule

// File: rtl/filter_arbiter.sv
// Round-robin read scheduler over the filter buffers with full-buffer priority,
// two-stage pop pipeline tagging each pair with its source filter ID.
module filter_arbiter
   import filter_arbiter_pkg::*;
(
   input logic              clk,
   input logic              rst,
   filter_arbiter_if.master bus
);

   logic [NUM_FILTER-1:0] nonempty_s;
   logic [NUM_FILTER-1:0] full_ne_s;
   logic [NUM_FILTER-1:0] full_grant_s;
   logic [NUM_FILTER-1:0] rr_grant_s;
   logic [NUM_FILTER-1:0] grant_oh_s;
   filter_id_t            full_idx_s;
   filter_id_t            rr_idx_s;
   filter_id_t            grant_idx_s;
   logic                  full_any_s;
   logic                  rr_any_s;
   logic                  grant_any_s;

   filter_id_t            rr_ptr_q, rr_ptr_d;
   logic                  s1_valid_q, s1_valid_d;
   filter_id_t            s1_id_q, s1_id_d;
   logic                  out_valid_q, out_valid_d;
   filter_id_t            out_id_q, out_id_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   // Full implies non-empty, but masking keeps an empty buffer from ever winning.
   assign nonempty_s = ~bus.filter_empty;
   assign full_ne_s  = bus.filter_full & nonempty_s;

   rr_priority_encoder #(.N(NUM_FILTER), .IDX_W(FILTER_ID_WIDTH)) u_full_enc (
      .req       (full_ne_s),
      .start     ({FILTER_ID_WIDTH{1'b0}}),
      .grant     (full_grant_s),
      .idx       (full_idx_s),
      .any_grant (full_any_s)
   );

   rr_priority_encoder #(.N(NUM_FILTER), .IDX_W(FILTER_ID_WIDTH)) u_rr_enc (
      .req       (nonempty_s),
      .start     (rr_ptr_q),
      .grant     (rr_grant_s),
      .idx       (rr_idx_s),
      .any_grant (rr_any_s)
   );

   // Grant selection: full-priority encoder wins over the round-robin one.
   always_comb begin
      grant_any_s = 1'b0;
      grant_idx_s = {FILTER_ID_WIDTH{1'b0}};
      grant_oh_s  = {NUM_FILTER{1'b0}};
      if (rst || bus.stall) begin
         grant_any_s = 1'b0;
      end else if (full_any_s) begin
         grant_any_s = 1'b1;
         grant_idx_s = full_idx_s;
         grant_oh_s  = full_grant_s;
      end else if (rr_any_s) begin
         grant_any_s = 1'b1;
         grant_idx_s = rr_idx_s;
         grant_oh_s  = rr_grant_s;
      end else begin
         grant_any_s = 1'b0;
      end
   end

   // Next-state: pointer advance, stage-1 tag capture, stage-2 data capture.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      s1_valid_d  = grant_any_s;
      s1_id_d     = s1_id_q;
      out_valid_d = s1_valid_q;
      out_id_d    = out_id_q;
      out_data_d  = out_data_q;
      if (grant_any_s) begin
         rr_ptr_d = next_id(grant_idx_s);
         s1_id_d  = grant_idx_s;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      // Buffer q is valid the cycle after rdreq, i.e. while stage 1 is valid.
      if (s1_valid_q) begin
         out_id_d   = s1_id_q;
         out_data_d = bus.filter_q[int'(s1_id_q)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         out_id_d   = out_id_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= {FILTER_ID_WIDTH{1'b0}};
         s1_valid_q  <= 1'b0;
         s1_id_q     <= {FILTER_ID_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         out_id_q    <= {FILTER_ID_WIDTH{1'b0}};
         out_data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         out_data_q  <= out_data_d;
      end
   end

   // Outputs: rdreq is the live grant, the rest come straight from flops.
   always_comb begin
      bus.filter_rdreq  = grant_oh_s;
      bus.out_valid     = out_valid_q;
      bus.out_filter_id = out_id_q;
      bus.out_data      = out_data_q;
      bus.idle          = (&bus.filter_empty) & ~s1_valid_q & ~out_valid_q;
   end

endmodule

// File: tb/tb_filter_arbiter.sv
// Directed bench for filter_arbiter with a behavioural model of the
// normal-mode filter FIFOs (q registered on the read edge).
module tb_filter_arbiter;
   import filter_arbiter_pkg::*;

   logic clk;
   logic rst;
   filter_arbiter_if bus();

   filter_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_fail;
   logic [31:0] mem [8][16];
   int          cnt [8];
   int          hd  [8];
   logic [31:0] q_r [8];
   logic [7:0]  full_v;
   int          pulses;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 8; i++) begin
         bus.filter_empty[i]         = (cnt[i] == 0);
         bus.filter_q[i*32 +: 32]    = q_r[i];
      end
      bus.filter_full = full_v;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         cnt[i] = 0;
         hd[i]  = 0;
         q_r[i] = 32'h0;
      end
      full_v = 8'h00;
   endtask

   task automatic push(input int f, input logic [31:0] d);
      mem[f][(hd[f] + cnt[f]) % 16] = d;
      cnt[f]++;
      drive();
   endtask

   task automatic settle();
      drive();
      #1;
   endtask

   // One clock: capture rdreq, pop the model after the edge, let logic settle.
   task automatic tick();
      logic [7:0] rq;
      rq = bus.filter_rdreq;
      @(posedge clk);
      #1;
      if (rst) begin
         clear_model();
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (rq[i] && cnt[i] > 0) begin
               q_r[i] = mem[i][hd[i]];
               hd[i]  = (hd[i] + 1) % 16;
               cnt[i]--;
            end
         end
      end
      drive();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      pulses    = 0;
      rst       = 1'b1;
      bus.stall = 1'b0;
      clear_model();
      drive();
      @(posedge clk);
      #1;

      // Test 1: reset held with random inputs
      for (int k = 0; k < 5; k++) begin
         bus.filter_empty = 8'($urandom);
         bus.filter_full  = 8'($urandom);
         bus.filter_q     = {8{32'($urandom)}};
         bus.stall        = 1'($urandom);
         #1;
         chk("rst_rdreq", 32'(bus.filter_rdreq), 32'h0);
         @(posedge clk);
         #1;
         chk("rst_valid", 32'(bus.out_valid), 32'h0);
         chk("rst_data", bus.out_data, 32'h0);
         chk("rst_id", 32'(bus.out_filter_id), 32'h0);
      end
      bus.stall = 1'b0;
      clear_model();
      rst = 1'b0;
      settle();
      chk("rst_idle", 32'(bus.idle), 32'h1);

      // Test 2: single buffer, three entries
      push(3, 32'h0A);
      push(3, 32'h0B);
      push(3, 32'h0C);
      settle();
      chk("t2_rdreq_c0", 32'(bus.filter_rdreq), 32'h08);
      tick();
      chk("t2_rdreq_c1", 32'(bus.filter_rdreq), 32'h08);
      chk("t2_valid_c1", 32'(bus.out_valid), 32'h0);
      tick();
      chk("t2_rdreq_c2", 32'(bus.filter_rdreq), 32'h08);
      chk("t2_valid_c2", 32'(bus.out_valid), 32'h1);
      chk("t2_data_c2", bus.out_data, 32'h0A);
      chk("t2_id_c2", 32'(bus.out_filter_id), 32'h3);
      tick();
      chk("t2_rdreq_c3", 32'(bus.filter_rdreq), 32'h00);
      chk("t2_data_c3", bus.out_data, 32'h0B);
      tick();
      chk("t2_valid_c4", 32'(bus.out_valid), 32'h1);
      chk("t2_data_c4", bus.out_data, 32'h0C);
      chk("t2_idle_c4", 32'(bus.idle), 32'h0);
      tick();
      chk("t2_valid_c5", 32'(bus.out_valid), 32'h0);
      chk("t2_hold_c5", bus.out_data, 32'h0C);
      chk("t2_idle_c5", 32'(bus.idle), 32'h1);

      // Test 3: all buffers busy, plain rotation
      do_reset();
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 2; j++) begin
            push(i, 32'hA000_0000 | 32'(i << 8) | 32'(j));
         end
      end
      settle();
      for (int k = 0; k < 10; k++) begin
         chk("t3_rdreq", 32'(bus.filter_rdreq), 32'(1 << (k % 8)));
         if (k >= 2) begin
            chk("t3_valid", 32'(bus.out_valid), 32'h1);
            chk("t3_id", 32'(bus.out_filter_id), 32'((k - 2) % 8));
            chk("t3_data", bus.out_data,
                32'hA000_0000 | 32'(((k - 2) % 8) << 8) | 32'((k - 2) / 8));
         end
         tick();
      end

      // Test 4: full priority, empty-full ignored, lowest full wins
      do_reset();
      push(0, 32'hB0);
      settle();
      chk("t4_rdreq_f0", 32'(bus.filter_rdreq), 32'h01);
      tick();
      for (int i = 1; i < 8; i++) push(i, 32'hB0 + 32'(i));
      full_v = 8'h20;
      settle();
      chk("t4_full5", 32'(bus.filter_rdreq), 32'h20);
      tick();
      full_v = 8'h01;
      settle();
      chk("t4_after5", 32'(bus.filter_rdreq), 32'h40);
      tick();
      chk("t4_rr7", 32'(bus.filter_rdreq), 32'h80);
      tick();
      full_v = 8'h15;
      settle();
      chk("t4_lowfull", 32'(bus.filter_rdreq), 32'h04);
      tick();
      full_v = 8'h00;
      settle();
      for (int i = 0; i < 20 && !bus.idle; i++) tick();
      chk("t4_drain_idle", 32'(bus.idle), 32'h1);

      // Test 5: stall during continuous traffic
      do_reset();
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) begin
            push(i, 32'hC000_0000 | 32'(i << 8) | 32'(j));
         end
      end
      settle();
      for (int k = 0; k < 10; k++) begin
         chk("t5_rdreq", 32'(bus.filter_rdreq), 32'(1 << (k % 8)));
         tick();
      end
      bus.stall = 1'b1;
      settle();
      pulses = 0;
      for (int k = 10; k < 16; k++) begin
         chk("t5_stall_rdreq", 32'(bus.filter_rdreq), 32'h0);
         if (bus.out_valid) pulses++;
         if (k == 10) begin
            chk("t5_id_c10", 32'(bus.out_filter_id), 32'h0);
            chk("t5_data_c10", bus.out_data, 32'hC000_0001);
         end
         tick();
      end
      chk("t5_pulses", 32'(pulses), 32'h2);
      chk("t5_hold_data", bus.out_data, 32'hC000_0101);
      bus.stall = 1'b0;
      settle();
      chk("t5_resume", 32'(bus.filter_rdreq), 32'h04);
      tick();
      chk("t5_resume2", 32'(bus.filter_rdreq), 32'h08);
      tick();

      // Test 6: reset with two reads in flight
      chk("t6_inflight", 32'(bus.out_valid), 32'h1);
      rst = 1'b1;
      settle();
      chk("t6_rst_rdreq", 32'(bus.filter_rdreq), 32'h0);
      tick();
      chk("t6_valid_after", 32'(bus.out_valid), 32'h0);
      rst = 1'b0;
      push(5, 32'hD5);
      push(2, 32'hD2);
      settle();
      chk("t6_from0", 32'(bus.filter_rdreq), 32'h04);
      chk("t6_valid_rel", 32'(bus.out_valid), 32'h0);
      chk("t6_idle", 32'(bus.idle), 32'h0);
      tick();
      tick();
      chk("t6_out_valid", 32'(bus.out_valid), 32'h1);
      chk("t6_out_id", 32'(bus.out_filter_id), 32'h2);
      chk("t6_out_data", bus.out_data, 32'hD2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
